// File: rtl/tc1_sensor_emu_pkg.sv
// Shared definitions for the TC1 thermocouple-sensor SPI emulator:
// state encoding, frame geometry and the frame packing helper.
package tc1_sensor_emu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    localparam int unsigned FRAME_W    = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned TC_W       = 14;
    localparam int unsigned INT_W      = 12;
    localparam int unsigned STATUS_W   = 3;

    localparam int unsigned TC_MSB     = 31;
    localparam int unsigned TC_LSB     = 18;
    localparam int unsigned FAULT_BIT  = 16;
    localparam int unsigned INT_MSB    = 15;
    localparam int unsigned INT_LSB    = 4;
    localparam int unsigned STATUS_MSB = 2;
    localparam int unsigned STATUS_LSB = 0;

    // Bits 17 and 3 are reserved and always read as zero.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [TC_W-1:0]     tc,
        input logic [INT_W-1:0]    cj,
        input logic [STATUS_W-1:0] st
    );
        logic [FRAME_W-1:0] f;
        f                         = '0;
        f[TC_MSB:TC_LSB]          = tc;
        f[FAULT_BIT]              = |st;
        f[INT_MSB:INT_LSB]        = cj;
        f[STATUS_MSB:STATUS_LSB]  = st;
        return f;
    endfunction

endpackage

// File: rtl/tc1_sync.sv
// Multi-flop synchronizer with a selectable reset preset value.
module tc1_sync #(
    parameter int unsigned STAGES = 2,
    parameter logic        PRESET = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= {STAGES{PRESET}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/tc1_sensor_emu.sv
// SPI slave emulating a thermocouple converter: shadow/pending capture of
// sensor values and a 32-bit MSB-first read frame shifted on SCLK falling edges.
module tc1_sensor_emu
    import tc1_sensor_emu_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SCLK,
    input  logic                CS,
    output logic                MISO,
    output logic                MISO_oe,
    input  logic [TC_W-1:0]     temperature_termoc,
    input  logic [INT_W-1:0]    temperature_internal,
    input  logic [STATUS_W-1:0] status,
    input  logic                load,
    output logic                busy,
    output logic                frame_done,
    output logic [CNT_W-1:0]    bits_read
);

    logic cs_s, sclk_s, cs_d, sclk_d;
    logic armed;
    logic [1:0] settle;
    logic settled, cs_fall, cs_rise, sclk_fall;

    state_t state, state_n;
    logic [FRAME_W-1:0] frame, frame_n, shadow, shadow_n, pending, pending_n, load_val;
    logic pend_v, pend_v_n;
    logic [CNT_W-1:0] cnt, cnt_n, bits_n;
    logic miso_n, done_n, act_n;

    tc1_sync #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(CS), .q(cs_s)
    );

    tc1_sync #(.STAGES(SYNC_STAGES), .PRESET(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(SCLK), .q(sclk_s)
    );

    // A frame may only start once CS has been genuinely observed high after
    // reset, so the synchronizer preset cannot fake a falling edge.
    assign settled   = (settle == 2'(SYNC_STAGES));
    assign cs_fall   = armed & cs_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;
    assign sclk_fall = sclk_d & ~sclk_s;
    assign load_val  = pack_frame(temperature_termoc, temperature_internal, status);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cs_d       <= 1'b1;
            sclk_d     <= 1'b0;
            armed      <= 1'b0;
            settle     <= 2'd0;
            frame      <= '0;
            shadow     <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            cnt        <= '0;
            bits_read  <= '0;
            MISO       <= 1'b0;
            MISO_oe    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cs_d       <= cs_s;
            sclk_d     <= sclk_s;
            armed      <= armed | (settled & cs_s);
            settle     <= settled ? settle : 2'(settle + 2'd1);
            frame      <= frame_n;
            shadow     <= shadow_n;
            pending    <= pending_n;
            pend_v     <= pend_v_n;
            cnt        <= cnt_n;
            bits_read  <= bits_n;
            MISO       <= miso_n;
            MISO_oe    <= act_n;
            busy       <= act_n;
            frame_done <= done_n;
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_n   = state;
        frame_n   = frame;
        shadow_n  = shadow;
        pending_n = pending;
        pend_v_n  = pend_v;
        cnt_n     = cnt;
        bits_n    = bits_read;
        miso_n    = 1'b0;
        done_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_n = ST_SHIFT;
                    frame_n = shadow;
                    cnt_n   = '0;
                    miso_n  = shadow[FRAME_W-1];
                    if (load) begin
                        pending_n = load_val;
                        pend_v_n  = 1'b1;
                    end
                end else if (load) begin
                    shadow_n = load_val;
                end
            end
            ST_SHIFT, ST_TAIL: begin
                if (cs_rise) begin
                    state_n  = ST_IDLE;
                    done_n   = 1'b1;
                    bits_n   = cnt;
                    pend_v_n = 1'b0;
                    if (load) begin
                        shadow_n = load_val;
                    end else if (pend_v) begin
                        shadow_n = pending;
                    end
                end else begin
                    if (load) begin
                        pending_n = load_val;
                        pend_v_n  = 1'b1;
                    end
                    if (state == ST_SHIFT) begin
                        miso_n = frame[FRAME_W-1];
                        if (sclk_fall) begin
                            frame_n = {frame[FRAME_W-2:0], 1'b0};
                            cnt_n   = CNT_W'(cnt + CNT_W'(1));
                            if (cnt_n == CNT_W'(FRAME_W)) begin
                                state_n = ST_TAIL;
                                miso_n  = 1'b0;
                            end else begin
                                miso_n = frame_n[FRAME_W-1];
                            end
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        act_n = (state_n != ST_IDLE);
    end

endmodule

// File: doc/tc1_sensor_emu.md
TC1_SENSOR_EMU -- requirements
Module: tc1_sensor_emu

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop synchronizer stages on SCLK and CS (legal range 2..3).
REQ-002 clk  input  1  system clock; one clock domain for all logic.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 SCLK  input  1  SPI clock from the master; idles low; must be at most clk/8.
REQ-005 CS  input  1  SPI chip select, active-low.
REQ-006 MISO  output  1  serial data to the master.
REQ-007 MISO_oe  output  1  output enable for MISO; high only while CS is synchronized-low.
REQ-008 temperature_termoc  input  14  thermocouple value, signed, 0.25 C/LSB.
REQ-009 temperature_internal  input  12  cold-junction value, signed, 0.0625 C/LSB.
REQ-010 status  input  3  fault flags {SCV, SCG, OC}.
REQ-011 load  input  1  single-clk strobe that captures temperature_termoc, temperature_internal and status into the shadow register.
REQ-012 busy  output  1  high while a frame is in progress (CS low).
REQ-013 frame_done  output  1  single-clk pulse when CS rises; asserted even when the frame is partial.
REQ-014 bits_read  output  6  number of SCLK falling edges seen in the last completed frame, saturating at 32.

Function
REQ-015 SCLK and CS shall each pass through SYNC_STAGES flops; edges are detected on the synchronized signals only.
REQ-016 State machine states:
  - IDLE: CS high.
  - SHIFT: CS low, fewer than 32 bits shifted.
  - TAIL: CS low, 32 bits shifted.
REQ-017 IDLE->SHIFT on the synchronized CS falling edge; the frame register loads from the shadow register in the same cycle.
REQ-018 Frame layout, MSB first: {temperature_termoc[13:0], 0, fault, temperature_internal[11:0], 0, status[2:0]}, where fault = |status.
REQ-019 Bit 31 shall appear on MISO no later than SYNC_STAGES+1 clk after CS falls.
REQ-020 On each synchronized SCLK falling edge, the frame shall shift left by one bit and the counter shall increment.
REQ-021 SHIFT->TAIL when the counter reaches 32; in TAIL, MISO shall be 0.
REQ-022 Any state->IDLE on the synchronized CS rising edge:
  - pulse frame_done;
  - latch bits_read;
  - drop MISO_oe and busy;
  - this is the only abort path; a partial frame is legal.
REQ-023 SCLK rising edges shall be ignored, because the master samples on rising edges.
REQ-024 load while IDLE shall update the shadow register on the next clk.
REQ-025 load while busy shall capture into a pending register; the pending value transfers to the shadow register in the cycle CS rises. The frame in flight is never modified.
REQ-026 Multiple loads during one frame: the last one wins.
REQ-027 load coincident with the CS falling-edge detect: the old shadow value goes out on the wire, and the new value is pending.
REQ-028 SCLK edges seen while CS is synchronized-high shall be ignored, and the counter shall not move.
REQ-029 When MISO_oe is low, MISO shall be driven 0.

Reset
REQ-030 On rst low, asynchronously:
  - state = IDLE;
  - MISO, MISO_oe, busy, frame_done = 0;
  - bits_read, counter, frame, shadow, pending = 0;
  - pending-valid = 0;
  - synchronizer flops preset to CS=1, SCLK=0.
REQ-031 Reset asserted mid-frame shall abort the frame with no frame_done pulse. After release, the block waits for a fresh CS falling edge, even if CS is already low.

Structure
REQ-032 A shared package shall hold:
  - the state encoding;
  - the frame width constant 32;
  - the field bit positions (TC 31:18, FAULT 16, INT 15:4, STATUS 2:0).
REQ-033 One sub-module, tc1_sync: a parameterized SYNC_STAGES synchronizer with a reset-preset value, instantiated twice (SCLK and CS).

Verification
REQ-034 Standard read:
  - stimulus: load termoc=14'h064, internal=12'h190, status=0; then a 32-clock SPI read at clk/10;
  - required: master receives 32'h01901900, frame_done pulses once, bits_read=32.
REQ-035 Fault read:
  - stimulus: load status=3'b001, other values as in REQ-034; then a 32-clock read;
  - required: master receives 32'h01911901.
REQ-036 Short read:
  - stimulus: 14 clocks, then CS high;
  - required: master receives 14'h064, bits_read=14, and the next full frame is correct from bit 31.
REQ-037 Load during frame:
  - stimulus: load termoc=14'h3FFC at bit 10 of a frame;
  - required: the current frame keeps 14'h064, and the next frame carries 14'h3FFC.
REQ-038 Reset mid-frame:
  - stimulus: rst low at bit 20, released with CS still low;
  - required: MISO_oe=0 and no frame_done; the next CS-low frame returns the reset-value frame 32'h00000000.
REQ-039 Over-clocking:
  - stimulus: 40 SCLK pulses in one frame;
  - required: bits 33..40 read 0, bits_read=32.
